ddr2_line_responder: RTL and testbench

- DDR2-side endpoint for the direct-mapped line cache. Accepts 128-bit line reads and write-backs on the cache's DDR2 request interface and drives them onto the MIG user interface (UI).
- Read data returns with a one-cycle available pulse. Write-backs are posted and produce no response, because the cache issues a write-back and the following refill read on consecutive cycles without waiting.

---
 rtl/ddr2_line_responder_pkg.sv | 27 ++
 rtl/ddr2_line_responder_if.sv | 46 ++++
 rtl/ddr2_line_responder_req_fifo.sv | 55 +++++
 rtl/ddr2_line_responder.sv | 177 +++++++++++++++++
 tb/tb_ddr2_line_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr2_line_responder_pkg.sv
// Shared types and constants for the DDR2 line responder.
// The read-watchdog build option is DDR2_RESP_TIMEOUT_EN; nothing here depends on it.
package ddr2_resp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef struct packed {
    logic         read;
    logic [22:0]  line_addr;
    logic [127:0] data;
  } ddr2_req_t;

  // Returned in place of real data when a read is abandoned by the watchdog.
  localparam logic [127:0] DEADBEEF_LINE = {4{32'hDEADBEEF}};

  function automatic logic [26:0] line_to_byte_addr(input logic [22:0] line_addr);
    return {line_addr, 4'b0000};
  endfunction

endpackage

// File: rtl/ddr2_line_responder_if.sv
// Bus bundles for the responder: the cache-side line request port and the MIG user interface.
// Handshakes: a cache request is one cycle of ddr2_enable (no backpressure); MIG command and
// write-data beats transfer on app_en&app_rdy and app_wdf_wren&app_wdf_rdy respectively.
interface ddr2_cache_if;
  logic         ddr2_enable;
  logic         ddr2_read;
  logic [26:0]  ddr2_addr;
  logic [127:0] to_ddr2_data;
  logic         ddr2_available;
  logic [127:0] ddr2_data;

  modport master (
    output ddr2_enable, ddr2_read, ddr2_addr, to_ddr2_data,
    input  ddr2_available, ddr2_data
  );

  modport slave (
    input  ddr2_enable, ddr2_read, ddr2_addr, to_ddr2_data,
    output ddr2_available, ddr2_data
  );
endinterface

interface mig_ui_if;
  logic         init_calib_complete;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr2_line_responder_req_fifo.sv
// Request FIFO between the cache port and the MIG issue FSM.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ddr2_req_fifo
  import ddr2_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      i_push,
  input  ddr2_req_t i_req,
  input  logic      i_pop,
  output ddr2_req_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  ddr2_req_t     r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_req;
  end

endmodule

// File: rtl/ddr2_line_responder.sv
// DDR2-side endpoint for the line cache: queues line reads/write-backs and issues them on the MIG UI.
// Optional read watchdog is compiled in with `define DDR2_RESP_TIMEOUT_EN.
module ddr2_line_responder
  import ddr2_resp_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic          clk,
  input  logic          rstn,
  ddr2_cache_if.slave   cache,
  mig_ui_if.master      mig,
  output logic          err_overflow,
  output logic          err_timeout,
  output state_t        o_dbg_state
);

  state_t r_state, r_state_next;

  ddr2_req_t w_push_req;
  ddr2_req_t w_head;
  logic      w_full;
  logic      w_empty;
  logic      w_pop;
  logic      w_cmd_fire;
  logic      w_wdat_fire;
  logic      w_rd_capture;
  logic      w_tmo_fire;

  logic         r_is_read;
  logic [22:0]  r_line_addr;
  logic [127:0] r_wdata;
  logic         r_cmd_done;
  logic         r_wdat_done;
  logic         r_avail;
  logic [127:0] r_rdata;
  logic         r_err_ovf;

  assign w_push_req = '{read:      cache.ddr2_read,
                        line_addr: cache.ddr2_addr[26:4],
                        data:      cache.to_ddr2_data};

  ddr2_req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (cache.ddr2_enable),
    .i_req   (w_push_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef DDR2_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_tmo;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WAIT_RD) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_fire  = (r_state == WAIT_RD) && !mig.app_rd_data_valid &&
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err_tmo;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_tmo_fire   = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  logic w_unused_addr;
  assign w_unused_addr = ^cache.ddr2_addr[3:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    w_pop        = 1'b0;
    w_cmd_fire   = 1'b0;
    w_wdat_fire  = 1'b0;
    w_rd_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && mig.init_calib_complete) begin
          w_pop        = 1'b1;
          r_state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Command and write beat complete independently; leave once both have transferred.
        w_cmd_fire  = !r_cmd_done && mig.app_rdy;
        w_wdat_fire = !r_wdat_done && mig.app_wdf_rdy;
        if ((r_cmd_done || w_cmd_fire) && (r_wdat_done || w_wdat_fire)) begin
          r_state_next = r_is_read ? WAIT_RD : IDLE;
        end
      end
      WAIT_RD: begin
        if (mig.app_rd_data_valid) begin
          w_rd_capture = 1'b1;
          r_state_next = IDLE;
        end else if (w_tmo_fire) begin
          r_state_next = IDLE;
        end
      end
      default: r_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_is_read   <= 1'b0;
      r_line_addr <= '0;
      r_wdata     <= '0;
      r_cmd_done  <= 1'b0;
      r_wdat_done <= 1'b0;
    end else if (w_pop) begin
      r_is_read   <= w_head.read;
      r_line_addr <= w_head.line_addr;
      r_wdata     <= w_head.data;
      r_cmd_done  <= 1'b0;
      r_wdat_done <= w_head.read;
    end else begin
      if (w_cmd_fire)  r_cmd_done  <= 1'b1;
      if (w_wdat_fire) r_wdat_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_avail   <= 1'b0;
      r_rdata   <= '0;
      r_err_ovf <= 1'b0;
    end else begin
      r_avail <= 1'b0;
      if (w_rd_capture) begin
        r_avail <= 1'b1;
        r_rdata <= mig.app_rd_data;
      end else if (w_tmo_fire) begin
        r_avail <= 1'b1;
        r_rdata <= DEADBEEF_LINE;
      end
      if (cache.ddr2_enable && w_full && !w_pop) r_err_ovf <= 1'b1;
    end
  end

`ifdef DDR2_RESP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           r_err_tmo <= 1'b0;
    else if (w_tmo_fire) r_err_tmo <= 1'b1;
  end
`endif

  assign mig.app_en       = (r_state == ISSUE) && !r_cmd_done;
  assign mig.app_wdf_wren = (r_state == ISSUE) && !r_wdat_done;
  assign mig.app_wdf_end  = mig.app_wdf_wren;
  assign mig.app_wdf_mask = '0;
  assign mig.app_addr     = line_to_byte_addr(r_line_addr);
  assign mig.app_cmd      = r_is_read ? CMD_READ : CMD_WRITE;
  assign mig.app_wdf_data = r_wdata;

  assign cache.ddr2_available = r_avail;
  assign cache.ddr2_data      = r_rdata;
  assign err_overflow         = r_err_ovf;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_ddr2_line_responder.sv
// Directed bench for ddr2_line_responder with a small MIG read-return model and
// expected queues for commands, write beats and read responses.
module tb_ddr2_line_responder;
  import ddr2_resp_pkg::*;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  logic   err_overflow;
  logic   err_timeout;
  state_t dbg_state;

  always #5 clk = ~clk;

  ddr2_cache_if cif ();
  mig_ui_if     mif ();

  ddr2_line_responder #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cache        (cif.slave),
    .mig          (mif.master),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout),
    .o_dbg_state  (dbg_state)
  );

  logic [29:0]  exp_cmd_q[$];
  logic [127:0] exp_wd_q[$];
  logic [127:0] exp_rsp_q[$];
  logic [127:0] ret_data_q[$];
  int           ret_due_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cmd_cnt  = 0;
  int avail_cnt = 0;
  int cyc      = 0;
  int rd_delay = 10;
  bit mig_ret_en = 1'b1;
  bit stray = 1'b0;
  int due_dummy;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_data(input logic [26:0] a);
    if (a[26:4] == 23'h000123) return 128'h0123456789ABCDEF0123456789ABCDEF;
    return {4{5'h0, a[26:4], 4'hA}};
  endfunction

  // Scoreboard side: every transfer the DUT makes must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (mif.app_en && mif.app_rdy) begin
        cmd_cnt++;
        check("cmd_expected", exp_cmd_q.size() != 0, 1'b1);
        if (exp_cmd_q.size() != 0) check("cmd", {mif.app_cmd, mif.app_addr}, exp_cmd_q.pop_front());
        if (mif.app_cmd == CMD_READ && mig_ret_en) begin
          ret_data_q.push_back(line_data(mif.app_addr));
          ret_due_q.push_back(cyc + 1 + rd_delay);
        end
      end
      if (mif.app_wdf_wren && mif.app_wdf_rdy) begin
        check("wdata_expected", exp_wd_q.size() != 0, 1'b1);
        if (exp_wd_q.size() != 0) check("wdata", mif.app_wdf_data, exp_wd_q.pop_front());
        check("wdf_end_mask", {mif.app_wdf_end, mif.app_wdf_mask}, 17'h10000);
      end
      if (cif.ddr2_available) begin
        avail_cnt++;
        check("rsp_expected", exp_rsp_q.size() != 0, 1'b1);
        if (exp_rsp_q.size() != 0) check("rsp_data", cif.ddr2_data, exp_rsp_q.pop_front());
      end
    end
  end

  // MIG read-return model.
  always @(posedge clk) begin
    cyc++;
    #1;
    mif.app_rd_data_valid = 1'b0;
    if (stray) begin
      mif.app_rd_data_valid = 1'b1;
      mif.app_rd_data = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
      stray = 1'b0;
    end else if (ret_due_q.size() != 0 && ret_due_q[0] <= cyc) begin
      mif.app_rd_data_valid = 1'b1;
      mif.app_rd_data = ret_data_q.pop_front();
      due_dummy = ret_due_q.pop_front();
    end
  end

  task automatic req(input bit rd, input logic [26:0] addr, input logic [127:0] data,
                     input bit expect_it);
    cif.ddr2_enable  = 1'b1;
    cif.ddr2_read    = rd;
    cif.ddr2_addr    = addr;
    cif.to_ddr2_data = data;
    if (expect_it) begin
      exp_cmd_q.push_back({rd ? CMD_READ : CMD_WRITE, addr[26:4], 4'b0000});
      if (!rd) exp_wd_q.push_back(data);
      if (rd && mig_ret_en) exp_rsp_q.push_back(line_data(addr));
    end
    @(posedge clk); #1;
    cif.ddr2_enable = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_cmd_q.size() == 0) && (exp_wd_q.size() == 0) && (exp_rsp_q.size() == 0) &&
             (ret_due_q.size() == 0) && (dbg_state == IDLE);
    end
    check({"drain_", tag}, done, 1'b1);
  endtask

  task automatic wait_state(input string tag, input state_t s);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (dbg_state == s);
    end
    check({"reach_", tag}, seen, 1'b1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, {cif.ddr2_available, err_overflow, err_timeout, mif.app_en,
                            mif.app_wdf_wren, mif.app_wdf_end, mif.app_cmd, mif.app_wdf_mask}, '0);
    check({tag, "_ddr2_data"}, cif.ddr2_data, '0);
    check({tag, "_app_addr"}, mif.app_addr, '0);
    check({tag, "_wdf_data"}, mif.app_wdf_data, '0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    int c0, a0, n;
    cif.ddr2_enable = 1'b0; cif.ddr2_read = 1'b0; cif.ddr2_addr = '0; cif.to_ddr2_data = '0;
    mif.init_calib_complete = 1'b1; mif.app_rdy = 1'b1; mif.app_wdf_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rstn = 1'b1;

    // Single read with a 2-cycle issue latency and 1-cycle response latency.
    req(1'b1, 27'h0001230, '0, 1'b1);
    @(negedge clk); check("lat_app_en_c1", mif.app_en, 1'b0);
    @(negedge clk); check("lat_app_en_c2", mif.app_en, 1'b1);
    check("t1_app_addr", mif.app_addr, 27'h0001230);
    check("t1_app_cmd", mif.app_cmd, CMD_READ);
    n = 0;
    while (!mif.app_rd_data_valid && n < 50) begin @(negedge clk); n++; end
    check("t1_rd_valid_seen", mif.app_rd_data_valid, 1'b1);
    @(negedge clk); check("lat_avail", cif.ddr2_available, 1'b1);
    @(negedge clk); check("avail_one_cycle", cif.ddr2_available, 1'b0);
    check("data_held", cif.ddr2_data, 128'h0123456789ABCDEF0123456789ABCDEF);
    wait_idle("t1");

    // Write-back then refill read on consecutive cycles.
    c0 = cmd_cnt; a0 = avail_cnt;
    req(1'b0, 27'h0400010, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 1'b1);
    req(1'b1, 27'h0000010, '0, 1'b1);
    wait_idle("t2");
    check("t2_cmd_count", cmd_cnt - c0, 2);
    check("t2_avail_count", avail_cnt - a0, 1);

    // Write data stalled while command is accepted.
    mif.app_wdf_rdy = 1'b0;
    c0 = cmd_cnt;
    req(1'b0, 27'h0000AB0, 128'hFEED_FACE_0000_0001_0000_0002_0000_0003, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_app_en_dropped", mif.app_en, 1'b0);
    check("t3_wren_held", {mif.app_wdf_wren, mif.app_wdf_end}, 2'b11);
    check("t3_one_cmd", cmd_cnt - c0, 1);
    @(posedge clk); #1 mif.app_wdf_rdy = 1'b1;
    wait_idle("t3");
    check("t3_no_dup_cmd", cmd_cnt - c0, 1);

    // Calibration low: fill FIFO, overflow on the fifth request.
    mif.init_calib_complete = 1'b0;
    c0 = cmd_cnt;
    req(1'b0, 27'h0000100, {4{32'h0000_0100}}, 1'b1);
    req(1'b1, 27'h0000200, '0, 1'b1);
    req(1'b0, 27'h0000300, {4{32'h0000_0300}}, 1'b1);
    req(1'b1, 27'h0000400, '0, 1'b1);
    check("t4_no_ovf_at_4", err_overflow, 1'b0);
    req(1'b0, 27'h0000500, {4{32'h0000_0500}}, 1'b0);
    repeat (5) @(negedge clk);
    check("t4_ovf", err_overflow, 1'b1);
    check("t4_no_app_en", mif.app_en, 1'b0);
    check("t4_no_cmd", cmd_cnt - c0, 0);
    @(posedge clk); #1 mif.init_calib_complete = 1'b1;
    wait_idle("t4");
    check("t4_four_cmds", cmd_cnt - c0, 4);
    check("t4_ovf_sticky", err_overflow, 1'b1);

    // Reset during WAIT_RD, then stray read data.
    mig_ret_en = 1'b0;
    a0 = avail_cnt;
    req(1'b1, 27'h0000770, '0, 1'b1);
    wait_state("t5_wait_rd", WAIT_RD);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    check_quiet("midreset");
    @(posedge clk); #1 rstn = 1'b1;
    stray = 1'b1;
    mig_ret_en = 1'b1;
    repeat (5) @(negedge clk);
    check_quiet("post_stray");
    check("t5_no_avail", avail_cnt - a0, 0);

`ifdef DDR2_RESP_TIMEOUT_EN
    // Read with no return: watchdog answers after 16 WAIT_RD cycles.
    mig_ret_en = 1'b0;
    exp_rsp_q.push_back({4{32'hDEADBEEF}});
    req(1'b1, 27'h0000880, '0, 1'b1);
    wait_state("t6_wait_rd", WAIT_RD);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_state != WAIT_RD) break;
      n++;
    end
    check("tmo_cycles", n, 16);
    check("tmo_avail", cif.ddr2_available, 1'b1);
    check("tmo_err", err_timeout, 1'b1);
    a0 = avail_cnt;
    stray = 1'b1;
    repeat (4) @(negedge clk);
    check("tmo_late_ignored", avail_cnt - a0, 0);
    check("tmo_err_sticky", err_timeout, 1'b1);
    mig_ret_en = 1'b1;
`else
    check("err_timeout_tied", err_timeout, 1'b0);
`endif

    wait_idle("final");
    check("final_queues_empty", exp_cmd_q.size() + exp_wd_q.size() + exp_rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
